// File: rtl/xava_data_arbiter.sv
// xava_data_arbiter: 2:1 OBI data-port arbiter in front of mm_ram.
// Port 0 is the cv32e40x core LSU and port 1 is the xava vector LSU.
// The owner FIFO records who owns each accepted transaction, so responses
// are routed back to the right master in order.
// Build option: define XAVA_DATA_ARB_ROUND_ROBIN_EN for round-robin arbitration.
// Without it, the core has fixed priority over the vector unit.
module xava_data_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [1:0]                m_req_i,
    output logic [1:0]                m_gnt_o,
    input  logic [2*ADDR_WIDTH-1:0]   m_addr_i,
    input  logic [1:0]                m_we_i,
    input  logic [2*DATA_WIDTH/8-1:0] m_be_i,
    input  logic [2*DATA_WIDTH-1:0]   m_wdata_i,
    output logic [1:0]                m_rvalid_o,
    output logic [DATA_WIDTH-1:0]     m_rdata_o,
    output logic                      s_req_o,
    input  logic                      s_gnt_i,
    output logic [ADDR_WIDTH-1:0]     s_addr_o,
    output logic                      s_we_o,
    output logic [DATA_WIDTH/8-1:0]   s_be_o,
    output logic [DATA_WIDTH-1:0]     s_wdata_o,
    input  logic                      s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     s_rdata_i,
    output logic                      spurious_o
);

    localparam int BEW = DATA_WIDTH / 8;
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW-1:0] MAXC  = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] LASTP = PW'(MAX_OUTSTANDING - 1);

    logic          r_lock;
    logic          r_lockOwner;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic          r_owner [MAX_OUTSTANDING];

    logic w_arbSel;
    logic w_sel;
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_head;

    // Pointer increment that wraps at the FIFO depth, including non-power-of-two depths.
    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == LASTP) ? '0 : p + 1'b1;
    endfunction

`ifdef XAVA_DATA_ARB_ROUND_ROBIN_EN
    logic r_rrLast;

    // Round-robin choice: on a tie, pick the master that did not win last time.
    always_comb begin
        w_arbSel = m_req_i[1];
        if (m_req_i == 2'b11) begin
            w_arbSel = ~r_rrLast;
        end
    end

    // Remember the winner of each accepted transaction for the next tie.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rrLast <= 1'b1;
        end else if (w_push) begin
            r_rrLast <= w_sel;
        end
    end
`else
    // Fixed priority: the core wins whenever it requests.
    always_comb begin
        w_arbSel = m_req_i[1] & ~m_req_i[0];
    end
`endif

    // Select a master and drive the memory port.
    // Grants are blocked while full, even if a response pops in the same cycle,
    // so there is no combinational path from rvalid to gnt.
    always_comb begin
        w_sel      = r_lock ? r_lockOwner : w_arbSel;
        w_full     = (r_count == MAXC);
        w_empty    = (r_count == '0);
        s_req_o    = ~rst_i & m_req_i[w_sel] & ~w_full;
        w_push     = s_req_o & s_gnt_i;
        w_pop      = s_rvalid_i & ~w_empty;
        w_head     = r_owner[r_rdPtr];
        s_addr_o   = w_sel ? m_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : m_addr_i[ADDR_WIDTH-1:0];
        s_we_o     = m_we_i[w_sel];
        s_be_o     = w_sel ? m_be_i[2*BEW-1:BEW] : m_be_i[BEW-1:0];
        s_wdata_o  = w_sel ? m_wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : m_wdata_i[DATA_WIDTH-1:0];
        m_gnt_o    = {w_push & w_sel, w_push & ~w_sel};
        m_rvalid_o = {w_pop & w_head, w_pop & ~w_head};
        m_rdata_o  = s_rdata_i;
        spurious_o = ~rst_i & s_rvalid_i & w_empty;
    end

    // Hold the selected master while memory stalls the address phase.
    // The lock is released on the cycle the handshake completes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lock      <= 1'b0;
            r_lockOwner <= 1'b0;
        end else if (w_push) begin
            r_lock <= 1'b0;
        end else if (s_req_o && !s_gnt_i) begin
            r_lock      <= 1'b1;
            r_lockOwner <= w_sel;
        end
    end

    // Owner FIFO: push the winner on accept, pop the head on each response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                r_owner[i] <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_owner[r_wrPtr] <= w_sel;
                r_wrPtr          <= nextPtr(r_wrPtr);
            end
            if (w_pop) begin
                r_rdPtr <= nextPtr(r_rdPtr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_xava_data_arbiter.sv
// Directed testbench for xava_data_arbiter.
// The bench uses the default parameters. Its expectations follow
// XAVA_DATA_ARB_ROUND_ROBIN_EN when that macro is defined.
module tb_xava_data_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mReq;
    logic [1:0]  mGnt;
    logic [63:0] mAddr;
    logic [1:0]  mWe;
    logic [7:0]  mBe;
    logic [63:0] mWdata;
    logic [1:0]  mRvalid;
    logic [31:0] mRdata;
    logic        sReq;
    logic        sGnt;
    logic [31:0] sAddr;
    logic        sWe;
    logic [3:0]  sBe;
    logic [31:0] sWdata;
    logic        sRvalid;
    logic [31:0] sRdata;
    logic        spurious;

    int checks   = 0;
    int failures = 0;

    // Free-running clock with a 10 ns period.
    always #5 clk = ~clk;

    xava_data_arbiter dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .m_req_i    (mReq),
        .m_gnt_o    (mGnt),
        .m_addr_i   (mAddr),
        .m_we_i     (mWe),
        .m_be_i     (mBe),
        .m_wdata_i  (mWdata),
        .m_rvalid_o (mRvalid),
        .m_rdata_o  (mRdata),
        .s_req_o    (sReq),
        .s_gnt_i    (sGnt),
        .s_addr_o   (sAddr),
        .s_we_o     (sWe),
        .s_be_o     (sBe),
        .s_wdata_o  (sWdata),
        .s_rvalid_i (sRvalid),
        .s_rdata_i  (sRdata),
        .spurious_o (spurious)
    );

    typedef struct packed {
        logic [1:0]  req;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic [1:0]  eGnt;
        logic        eSreq;
        logic [31:0] eAddr;
        logic [1:0]  eRvalid;
        logic        eSpur;
    } vec_t;

    vec_t vecs [10];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, then wait until mid-cycle.
    task automatic applyStimulus(input logic [1:0] req, input logic gnt, input logic rv, input logic [31:0] rdata);
        mReq    = req;
        sGnt    = gnt;
        sRvalid = rv;
        sRdata  = rdata;
        #4;
    endtask

    task automatic checkCycle(input string tag, input logic [1:0] eGnt, input logic eSreq,
                              input logic [1:0] eRvalid, input logic eSpur);
        checkOutput({tag, ".gnt"}, {30'd0, mGnt}, {30'd0, eGnt});
        checkOutput({tag, ".sreq"}, {31'd0, sReq}, {31'd0, eSreq});
        checkOutput({tag, ".rvalid"}, {30'd0, mRvalid}, {30'd0, eRvalid});
        checkOutput({tag, ".spur"}, {31'd0, spurious}, {31'd0, eSpur});
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
        nextCycle();
        nextCycle();
        rst = 1'b0;
    endtask

    initial begin
        mAddr  = {32'h0000_0200, 32'h0000_0100};
        mWe    = 2'b10;
        mBe    = 8'hF_F;
        mWdata = {32'hCAFE_0001, 32'h1234_5678};
        rst    = 1'b1;
        applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);

        // Reset state: nothing requested, granted or returned.
        checkCycle("reset", 2'b00, 1'b0, 2'b00, 1'b0);
        nextCycle();
        nextCycle();
        rst = 1'b0;

        // Core read, in-order interleaving, full blocking, and stray responses.
        vecs[0] = '{2'b01, 1'b1, 1'b0, 32'h0,         2'b01, 1'b1, 32'h100, 2'b00, 1'b0};
        vecs[1] = '{2'b00, 1'b0, 1'b1, 32'hDEADBEEF,  2'b00, 1'b0, 32'h0,   2'b01, 1'b0};
        vecs[2] = '{2'b00, 1'b0, 1'b1, 32'h0,         2'b00, 1'b0, 32'h0,   2'b00, 1'b1};
        vecs[3] = '{2'b01, 1'b1, 1'b0, 32'h0,         2'b01, 1'b1, 32'h100, 2'b00, 1'b0};
        vecs[4] = '{2'b10, 1'b1, 1'b0, 32'h0,         2'b10, 1'b1, 32'h200, 2'b00, 1'b0};
        vecs[5] = '{2'b01, 1'b1, 1'b1, 32'h0000AAAA,  2'b00, 1'b0, 32'h0,   2'b01, 1'b0};
        vecs[6] = '{2'b01, 1'b1, 1'b1, 32'h0000BBBB,  2'b01, 1'b1, 32'h100, 2'b10, 1'b0};
        vecs[7] = '{2'b00, 1'b0, 1'b0, 32'h0,         2'b00, 1'b0, 32'h0,   2'b00, 1'b0};
        vecs[8] = '{2'b00, 1'b0, 1'b1, 32'h0000CCCC,  2'b00, 1'b0, 32'h0,   2'b01, 1'b0};
        vecs[9] = '{2'b00, 1'b0, 1'b1, 32'h0,         2'b00, 1'b0, 32'h0,   2'b00, 1'b1};

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].req, vecs[i].gnt, vecs[i].rv, vecs[i].rdata);
            checkCycle($sformatf("vec%0d", i), vecs[i].eGnt, vecs[i].eSreq, vecs[i].eRvalid, vecs[i].eSpur);
            if (vecs[i].eSreq) begin
                checkOutput($sformatf("vec%0d.addr", i), sAddr, vecs[i].eAddr);
            end
            if (vecs[i].eRvalid != 2'b00) begin
                checkOutput($sformatf("vec%0d.rdata", i), mRdata, vecs[i].rdata);
            end
            nextCycle();
        end

        // Both masters request continuously for 8 accepts, with one response per cycle.
        doReset();
        begin
            logic [1:0] prevGnt;
            logic [1:0] expGnt;
            prevGnt = 2'b00;
            for (int k = 0; k < 9; k++) begin
`ifdef XAVA_DATA_ARB_ROUND_ROBIN_EN
                expGnt = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
                expGnt = 2'b01;
`endif
                if (k == 8) begin
                    expGnt = 2'b00;
                end
                applyStimulus((k < 8) ? 2'b11 : 2'b00, 1'b1, (k > 0), 32'h0);
                checkOutput($sformatf("tie%0d.gnt", k), {30'd0, mGnt}, {30'd0, expGnt});
                checkOutput($sformatf("tie%0d.rvalid", k), {30'd0, mRvalid}, {30'd0, prevGnt});
                prevGnt = expGnt;
                nextCycle();
            end
        end

        // Vector address phase stalled for 3 cycles; the core joins in cycle 2.
        doReset();
        for (int k = 1; k <= 4; k++) begin
            applyStimulus((k == 1) ? 2'b10 : 2'b11, (k == 4), 1'b0, 32'h0);
            checkOutput($sformatf("lock%0d.sreq", k), {31'd0, sReq}, 32'd1);
            checkOutput($sformatf("lock%0d.addr", k), sAddr, 32'h200);
            checkOutput($sformatf("lock%0d.we", k), {31'd0, sWe}, 32'd1);
            checkOutput($sformatf("lock%0d.wdata", k), sWdata, 32'hCAFE_0001);
            checkOutput($sformatf("lock%0d.gnt", k), {30'd0, mGnt}, (k == 4) ? 32'd2 : 32'd0);
            nextCycle();
        end
        applyStimulus(2'b01, 1'b1, 1'b1, 32'h0);
        checkCycle("lockA", 2'b01, 1'b1, 2'b10, 1'b0);
        nextCycle();
        applyStimulus(2'b00, 1'b0, 1'b1, 32'h0);
        checkCycle("lockB", 2'b00, 1'b0, 2'b01, 1'b0);
        nextCycle();

        // Memory withholds responses after two accepts.
        doReset();
        applyStimulus(2'b01, 1'b1, 1'b0, 32'h0);
        checkCycle("full0", 2'b01, 1'b1, 2'b00, 1'b0);
        nextCycle();
        applyStimulus(2'b01, 1'b1, 1'b0, 32'h0);
        checkCycle("full1", 2'b01, 1'b1, 2'b00, 1'b0);
        nextCycle();
        applyStimulus(2'b01, 1'b1, 1'b0, 32'h0);
        checkCycle("full2", 2'b00, 1'b0, 2'b00, 1'b0);
        nextCycle();
        applyStimulus(2'b01, 1'b1, 1'b1, 32'h0);
        checkCycle("full3", 2'b00, 1'b0, 2'b01, 1'b0);
        nextCycle();
        applyStimulus(2'b01, 1'b1, 1'b0, 32'h0);
        checkCycle("full4", 2'b01, 1'b1, 2'b00, 1'b0);
        nextCycle();
        applyStimulus(2'b00, 1'b0, 1'b1, 32'h0);
        checkCycle("full5", 2'b00, 1'b0, 2'b01, 1'b0);
        nextCycle();
        applyStimulus(2'b00, 1'b0, 1'b1, 32'h0);
        checkCycle("full6", 2'b00, 1'b0, 2'b01, 1'b0);
        nextCycle();

        // Reset with one core transaction outstanding and the vector locked.
        doReset();
        applyStimulus(2'b01, 1'b1, 1'b0, 32'h0);
        checkCycle("rst0", 2'b01, 1'b1, 2'b00, 1'b0);
        nextCycle();
        applyStimulus(2'b10, 1'b0, 1'b0, 32'h0);
        checkCycle("rst1", 2'b00, 1'b1, 2'b00, 1'b0);
        nextCycle();
        rst = 1'b1;
        applyStimulus(2'b11, 1'b1, 1'b1, 32'h0);
        checkCycle("rstOn", 2'b00, 1'b0, 2'b00, 1'b0);
        nextCycle();
        rst = 1'b0;
        applyStimulus(2'b00, 1'b0, 1'b1, 32'h0);
        checkCycle("rstSpur", 2'b00, 1'b0, 2'b00, 1'b1);
        nextCycle();
        applyStimulus(2'b01, 1'b1, 1'b0, 32'h0);
        checkCycle("rstUnlock", 2'b01, 1'b1, 2'b00, 1'b0);
        checkOutput("rstUnlock.addr", sAddr, 32'h100);
        nextCycle();
        applyStimulus(2'b00, 1'b0, 1'b1, 32'h0);
        checkCycle("rstDrain", 2'b00, 1'b0, 2'b01, 1'b0);
        nextCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
